// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus responder: FSM state encoding and
// the width of the wait-state down-counter.
package bus_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port WORDS x 16 storage with per-byte write enables and a registered
// read port. Contents are never cleared; reset does not reach this block.
module mem_bank #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    we,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-mapped responder: decodes a word window, sequences IDLE/WAIT/ACK and
// fronts a byte-writable mem_bank.
// Handshake: the initiator raises m_access with address/data/controls stable
// and holds it until m_ack; m_ack is a one-cycle pulse at which read data is
// valid on m_data_in and a write commits. Dropping m_access early aborts.
module mem_bus_responder
    import bus_pkg::*;
#(
    parameter int WORDS       = 4096,
    parameter int WAIT_STATES = 1,
    parameter int BASE_WORD   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:1] m_addr,
    output logic [15:0] m_data_in,
    input  logic [15:0] m_data_out,
    input  logic        m_access,
    output logic        m_ack,
    input  logic        m_wr_en,
    input  logic [1:0]  m_bytesel,
    output logic [1:0]  dbg_state
);

    localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [18:0] BASE    = 19'(BASE_WORD);
    localparam logic [19:0] WORDS_L = 20'(WORDS);

    state_t              state, state_next;
    logic [WAIT_W-1:0]   cnt, cnt_next;
    logic                capture;

    logic [18:0]   offset;
    logic          in_range;
    logic [AW-1:0] addr_q;
    logic [15:0]   data_q;
    logic          wr_q;
    logic          hit_q;
    logic [1:0]    bsel_q;

    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_we;
    logic [15:0]   ram_rdata;

    // Addresses below BASE wrap to a huge offset, so they can never alias in.
    assign offset   = m_addr - BASE;
    assign in_range = ({1'b0, offset} < WORDS_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            hit_q  <= 1'b0;
            bsel_q <= 2'b00;
        end else if (capture) begin
            addr_q <= offset[AW-1:0];
            data_q <= m_data_out;
            wr_q   <= m_wr_en;
            hit_q  <= in_range;
            bsel_q <= m_bytesel;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_access) begin
                    capture    = 1'b1;
                    cnt_next   = 4'(WAIT_STATES);
                    state_next = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!m_access) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                    if (cnt_next == '0) state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // In IDLE the bank is addressed straight from the bus so a zero-wait read
    // has its registered data ready in the ACK cycle.
    assign ram_addr = (state == ST_IDLE) ? offset[AW-1:0] : addr_q;
    assign ram_we   = (state == ST_ACK && wr_q && hit_q) ? bsel_q : 2'b00;

    assign m_ack     = (state == ST_ACK);
    assign m_data_in = (state == ST_ACK && !wr_q) ? (hit_q ? ram_rdata : 16'hFFFF) : 16'h0000;
    assign dbg_state = state;

    mem_bank #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances with different wait states and
// windows, a scoreboard queue filled by the driver and drained by a monitor.
module tb_mem_bus_responder;
    import bus_pkg::*;

    localparam int N_DUT = 3;

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction
    function automatic int base_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 8 : 'h7FFE0;
    endfunction
    function automatic int words_of(input int i);
        return (i == 0) ? 64 : (i == 1) ? 16 : 32;
    endfunction

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] cyc;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [18:0] m_addr     [N_DUT];
    logic [15:0] m_data_out [N_DUT];
    logic        m_access   [N_DUT];
    logic        m_wr_en    [N_DUT];
    logic [1:0]  m_bytesel  [N_DUT];
    logic [15:0] m_data_in  [N_DUT];
    logic        m_ack      [N_DUT];
    logic [1:0]  dbg_state  [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_bus_responder #(
            .WORDS       (words_of(g)),
            .WAIT_STATES (ws_of(g)),
            .BASE_WORD   (base_of(g))
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .m_addr     (m_addr[g]),
            .m_data_in  (m_data_in[g]),
            .m_data_out (m_data_out[g]),
            .m_access   (m_access[g]),
            .m_ack      (m_ack[g]),
            .m_wr_en    (m_wr_en[g]),
            .m_bytesel  (m_bytesel[g]),
            .dbg_state  (dbg_state[g])
        );
    end

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] model_mem [N_DUT][64];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic model_hit(input int i, input logic [18:0] a);
        int ai;
        ai = int'(a);
        return (ai >= base_of(i)) && (ai < base_of(i) + words_of(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_access(input int i, input logic [18:0] a, input logic wr,
                             input logic [15:0] d, input logic [1:0] bs);
        exp_t e;
        logic got;
        int   idx;
        e.id   = 2'(i);
        e.cyc  = 32'(cyc + 1 + ws_of(i));
        e.rd   = !wr;
        e.data = 16'h0000;
        if (model_hit(i, a)) begin
            idx = int'(a) - base_of(i);
            if (wr) begin
                if (bs[0]) model_mem[i][idx][7:0]  = d[7:0];
                if (bs[1]) model_mem[i][idx][15:8] = d[15:8];
            end else begin
                e.data = model_mem[i][idx];
            end
        end else if (!wr) begin
            e.data = 16'hFFFF;
        end
        exp_q.push_back(e);
        m_addr[i]     = a;
        m_data_out[i] = d;
        m_wr_en[i]    = wr;
        m_bytesel[i]  = bs;
        m_access[i]   = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 32 && !got; t++) begin
            @(negedge clk);
            got = m_ack[i];
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout dut%0d addr=%h: no ack in 32 cycles, required one", i, a);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        m_access[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_DUT; i++) begin
                if (m_ack[i]) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d, required none", i, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk($sformatf("ack_dut%0d", i), 32'(mon_e.id), 32'(i));
                        chk($sformatf("ack_cycle_dut%0d", i), 32'(cyc), mon_e.cyc);
                        if (mon_e.rd)
                            chk($sformatf("read_data_dut%0d", i), 32'(m_data_in[i]), 32'(mon_e.data));
                    end
                end else begin
                    chk($sformatf("idle_data_dut%0d", i), 32'(m_data_in[i]), 32'h0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [15:0] old_v;
    initial begin
        reset = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            m_addr[i] = '0; m_data_out[i] = '0; m_access[i] = 1'b0;
            m_wr_en[i] = 1'b0; m_bytesel[i] = 2'b00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("reset_state_dut%0d", i), 32'(dbg_state[i]), 32'(ST_IDLE));
            chk($sformatf("reset_ack_dut%0d", i), 32'(m_ack[i]), 32'h0);
            chk($sformatf("reset_data_dut%0d", i), 32'(m_data_in[i]), 32'h0);
        end
        reset = 1'b0;

        // Fill every word; the first access lands on the first edge after reset.
        for (int i = 0; i < N_DUT; i++)
            for (int w = 0; w < words_of(i); w++)
                do_access(i, 19'(base_of(i) + w), 1'b1, 16'($urandom), 2'b11);

        // Full write then readback, partial low-byte overwrite, byte-less write.
        do_access(0, 19'h10, 1'b1, 16'hBEEF, 2'b11);
        do_access(0, 19'h10, 1'b0, 16'h0, 2'b00);
        do_access(0, 19'h10, 1'b1, 16'h1234, 2'b01);
        do_access(0, 19'h10, 1'b0, 16'h0, 2'b00);
        do_access(0, 19'h11, 1'b1, 16'h5A5A, 2'b00);
        do_access(0, 19'h11, 1'b0, 16'h0, 2'b00);
        do_access(0, 19'h12, 1'b1, 16'hC3D4, 2'b10);
        do_access(0, 19'h12, 1'b0, 16'h0, 2'b00);

        // Just past the window: reads FFFF, writes must not land anywhere.
        do_access(0, 19'd64, 1'b0, 16'h0, 2'b00);
        do_access(0, 19'd64, 1'b1, 16'hDEAD, 2'b11);
        do_access(0, 19'd0, 1'b0, 16'h0, 2'b00);
        do_access(0, 19'd64, 1'b0, 16'h0, 2'b00);

        // Zero-wait instance: back-to-back reads, below-base and in-window, RAW.
        idle(2);
        do_access(1, 19'h0, 1'b0, 16'h0, 2'b00);
        do_access(1, 19'h1, 1'b0, 16'h0, 2'b00);
        do_access(1, 19'h7, 1'b0, 16'h0, 2'b00);
        do_access(1, 19'h8, 1'b0, 16'h0, 2'b00);
        do_access(1, 19'h9, 1'b1, 16'h7E81, 2'b11);
        do_access(1, 19'h9, 1'b0, 16'h0, 2'b00);
        do_access(1, 19'h17, 1'b0, 16'h0, 2'b00);
        do_access(1, 19'h18, 1'b0, 16'h0, 2'b00);

        // Reset in the middle of a write's WAIT state.
        idle(2);
        old_v = model_mem[0][32];
        m_addr[0] = 19'h20; m_data_out[0] = ~old_v; m_wr_en[0] = 1'b1;
        m_bytesel[0] = 2'b11; m_access[0] = 1'b1;
        @(posedge clk);
        #2;
        chk("wait_before_reset", 32'(dbg_state[0]), 32'(ST_WAIT));
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        chk("async_reset_ack", 32'(m_ack[0]), 32'h0);
        chk("async_reset_data", 32'(m_data_in[0]), 32'h0);
        m_access[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_access(0, 19'h20, 1'b0, 16'h0, 2'b00);

        // Abort a write on the 3-wait instance by dropping m_access mid-WAIT.
        idle(1);
        m_addr[2] = 19'h7FFE5; m_data_out[2] = ~model_mem[2][5]; m_wr_en[2] = 1'b1;
        m_bytesel[2] = 2'b11; m_access[2] = 1'b1;
        idle(2);
        chk("abort_in_wait", 32'(dbg_state[2]), 32'(ST_WAIT));
        m_access[2] = 1'b0;
        idle(1);
        chk("abort_state", 32'(dbg_state[2]), 32'(ST_IDLE));
        chk("abort_ack", 32'(m_ack[2]), 32'h0);
        idle(6);
        do_access(2, 19'h7FFE5, 1'b0, 16'h0, 2'b00);
        do_access(2, 19'h0, 1'b0, 16'h0, 2'b00);
        do_access(2, 19'h7FFDF, 1'b0, 16'h0, 2'b00);

        // Randomized mix across all instances with random gaps.
        for (int n = 0; n < 300; n++) begin
            int          i;
            int          r;
            logic [18:0] a;
            i = int'($urandom_range(0, N_DUT - 1));
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 19'(base_of(i) + int'($urandom_range(0, words_of(i) - 1)));
            else if (r == 8) a = 19'(base_of(i) + words_of(i));
            else             a = 19'(base_of(i) - 1);
            do_access(i, a, 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)));
            r = int'($urandom_range(0, 2));
            if (r > 0) idle(r);
        end

        idle(8);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
